conv_encoder_param: RTL
=======================

Name: conv_encoder_param

Overview:
- Parametrised rate-1/N feed-forward convolutional encoder; generalises the fixed K=9, rate-1/2 encoder to any constraint length, output count and generator set.
- Adds valid/ready handshaking on both sides, frame delimiting, and optional zero-tail termination so each frame starts and ends in state 0.
- Sits between the bit source and the modulator or channel model, and is the stimulus source for the Viterbi decoder bench.

Parameters:
- K, 9, constraint length (2..16); shift state is K-1 bits.
- N, 2, output bits per input bit (2..4).
- POLYS, {9'b110_101_111, 9'b100_011_101}, N*K-bit concatenated generators; the most significant K bits drive Y[N-1]. Within each generator, bit K-1 taps the current input and bit 0 taps the oldest state bit.
- TAIL_EN, 1, 1 = append K-1 zero tail bits after In_Last; 0 = no tail.

Ports:
- Clock  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- X  in  1  information bit.
- In_Valid  in  1  X and In_Last are valid.
- In_Last  in  1  X is the final bit of its frame.
- In_Ready  out  1  encoder can accept X this cycle.
- Y  out  N  encoded symbol (registered).
- Out_Valid  out  1  Y is valid.
- Out_Last  out  1  Y is the final symbol of the frame.
- Out_Ready  in  1  downstream accepts Y this cycle.

Behaviour:
- Reset low (asynchronous): shift state = 0, FSM = RUN, tail count = 0, Y = 0, Out_Valid = 0, Out_Last = 0. In_Ready = 1 once Reset is high.
- Symbol rule: v = {b, state[K-2:0]}, where b is the encoded bit (X, or 0 during the tail) and state[K-2] is the most recent past bit. Y[i] = XOR-reduce(POLYS generator i & v). After each encode, state <= v[K-1:1].
- Output stage is a single register: load_ok = !Out_Valid || Out_Ready.
- RUN state:
  - In_Ready = load_ok.
  - Accept when In_Valid && In_Ready.
  - On accept, register Y and set Out_Valid = 1 on the next edge (latency 1 cycle).
  - Out_Last = In_Last && !TAIL_EN.
- Accepting In_Last:
  - TAIL_EN=1: go to FLUSH with tail count = 0.
  - TAIL_EN=0: stay in RUN and clear the shift state to 0 after this encode.
- FLUSH state:
  - In_Ready = 0.
  - Each cycle with load_ok, encode b=0 and increment the tail count.
  - The (K-1)th tail symbol carries Out_Last = 1; go to RUN. The state is then all zeros by construction.
- Out_Valid deasserts after a handshake only if no new symbol loads in the same cycle.
- While Out_Valid && !Out_Ready:
  - Y, Out_Last and the shift state hold stable.
  - In_Ready = 0 and FLUSH does not advance.
- Full throughput: one symbol per cycle with In_Valid = Out_Ready = 1 continuously. A new frame may be accepted in the cycle after the last tail symbol loads.
- Simultaneous events:
  - An output handshake and a new load in the same cycle: the new value wins and Out_Valid stays 1.
  - In_Valid during FLUSH is ignored; the upstream source holds it.
- Reset mid-frame or mid-flush: immediate return to the reset values. Any partial frame is discarded, with no Out_Last emitted.
- In_Last on a frame's first bit is legal: 1 data symbol plus K-1 tail symbols.
- Frame length is unbounded; no internal counter wraps except the tail count, which is clog2(K) bits wide.

Test Plan:
- Reset check:
  - Stimulus: hold Reset low, toggle inputs.
  - Required: Y=0, Out_Valid=0, Out_Last=0; after release In_Ready=1.
- Impulse response (default parameters):
  - Stimulus: X=1 with In_Last, Out_Ready held at 1.
  - Required: 9 symbols 11,10,00,10,01,11,11,10,11; Out_Last only on the 9th; In_Ready=0 for those 8 tail cycles.
- Backpressure:
  - Stimulus: stream 1,0,1,1 with Out_Ready toggling 1,0,0,1,...
  - Required: Y holds while stalled; symbol sequence identical to the no-stall run; no bit lost or duplicated.
- Back-to-back frames:
  - Stimulus: frame A = {1,1} (Last), then frame B = {1} (Last) immediately.
  - Required: frame B's first symbol is 11, proving state 0; two Out_Last pulses, 10 and 9 symbols apart.
- TAIL_EN=0, K=7, N=3, POLYS = {7'b1011011, 7'b1111001, 7'b1110101}:
  - Stimulus: X=1 with Last, then X=1.
  - Required: outputs 111 (Out_Last=1) then 111; no tail symbols.
- Reset mid-flush:
  - Stimulus: assert Reset during the 3rd tail symbol of the impulse test, then release and send X=1, Last.
  - Required: no Out_Last before reset; the fresh frame reproduces the exact impulse sequence.

Source files
------------

// File: rtl/conv_encoder_param.sv
// rtl/conv_encoder_param.sv - parametrised rate-1/N feed-forward convolutional encoder
// Valid/ready on both sides, frame delimiting and optional zero-tail termination.
module conv_encoder_param #(
  parameter int K = 9,
  parameter int N = 2,
  parameter logic [N*K-1:0] POLYS = {9'b110_101_111, 9'b100_011_101},
  parameter bit TAIL_EN = 1'b1
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         X,
  input  logic         In_Valid,
  input  logic         In_Last,
  output logic         In_Ready,
  output logic [N-1:0] Y,
  output logic         Out_Valid,
  output logic         Out_Last,
  input  logic         Out_Ready
);

  localparam int TW = $clog2(K);

  typedef enum logic {RUN, FLUSH} fsmState_t;

  fsmState_t      fsmState;
  logic [K-2:0]   shiftState;
  logic [TW-1:0]  tailCount;
  logic           loadOk;
  logic           accept;
  logic           flushStep;
  logic           encBit;
  logic [K-1:0]   symbolIn;
  logic [N-1:0]   yNext;

  assign loadOk    = !Out_Valid || Out_Ready;
  assign In_Ready  = Reset && (fsmState == RUN) && loadOk;
  assign accept    = In_Valid && In_Ready;
  assign flushStep = (fsmState == FLUSH) && loadOk;
  assign encBit    = (fsmState == RUN) ? X : 1'b0;
  // Bit K-1 is the bit being encoded, bit 0 the oldest remembered bit.
  assign symbolIn  = {encBit, shiftState};

  always_comb begin
    yNext = '0;
    for (int i = 0; i < N; i++) begin
      yNext[i] = ^(POLYS[i*K +: K] & symbolIn);
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      fsmState   <= RUN;
      shiftState <= '0;
      tailCount  <= '0;
      Y          <= '0;
      Out_Valid  <= 1'b0;
      Out_Last   <= 1'b0;
    end else if (accept || flushStep) begin
      Y          <= yNext;
      Out_Valid  <= 1'b1;
      shiftState <= symbolIn[K-1:1];
      if (accept) begin
        Out_Last <= In_Last && !TAIL_EN;
        if (In_Last) begin
          if (TAIL_EN) begin
            fsmState  <= FLUSH;
            tailCount <= '0;
          end else begin
            shiftState <= '0;
          end
        end
      end else begin
        tailCount <= tailCount + TW'(1);
        if (tailCount == TW'(K - 2)) begin
          Out_Last <= 1'b1;
          fsmState <= RUN;
        end else begin
          Out_Last <= 1'b0;
        end
      end
    end else if (Out_Ready) begin
      Out_Valid <= 1'b0;
    end
  end

endmodule
